// File: rtl/d_bus_arbiter_if.sv
// rtl/d_bus_arbiter_if.sv - requester, shared data-bus and target-strobe signals of d_bus_arbiter
interface d_bus_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        cpu_ack;
    logic        dma_ack;
    logic [15:0] rdata;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_oe;
    logic [15:0] d_bus_in;
    logic        mem_read;
    logic        mem_write;
    logic        io_read;
    logic        io_write;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  d_bus_in,
        output cpu_ack, dma_ack, rdata,
        output d_addr, d_wdata, d_oe,
        output mem_read, mem_write, io_read, io_write
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output d_bus_in,
        input  cpu_ack, dma_ack, rdata,
        input  d_addr, d_wdata, d_oe,
        input  mem_read, mem_write, io_read, io_write
    );
endinterface

// File: rtl/d_bus_arbiter.sv
// rtl/d_bus_arbiter.sv - CPU/DMA arbiter for the shared d_bus with mem/io decode; `ROUND_ROBIN_EN selects fair arbitration
module d_bus_arbiter #(
    parameter logic [15:0] IO_BASE = 16'hFF00
) (
    input  logic            clk,
    input  logic            rst_n,
    d_bus_arbiter_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RDAT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    logic [1:0]  state;
    logic        owner;
    logic        last_owner;
    logic        lat_we;
    logic [15:0] d_addr_q;
    logic [15:0] d_wdata_q;
    logic [15:0] rdata_q;
    logic        d_oe_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        io_read_q;
    logic        io_write_q;
    logic        cpu_ack_q;
    logic        dma_ack_q;

    logic        grant_valid;
    logic        grant_owner;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        sel_io;

    // Requests only feed the next-state logic; every output below is a flop.
    always_comb begin
        grant_valid = bus.cpu_req | bus.dma_req;
        grant_owner = OWNER_CPU;
        if (bus.cpu_req && bus.dma_req) begin
`ifdef ROUND_ROBIN_EN
            grant_owner = ~last_owner;
`else
            grant_owner = OWNER_CPU;
`endif
        end else if (bus.dma_req) begin
            grant_owner = OWNER_DMA;
        end
    end

`ifndef ROUND_ROBIN_EN
    // Fixed priority never consults the grant history, but it is still tracked.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (grant_owner == OWNER_DMA) begin
            sel_we    = bus.dma_we;
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
        end
        sel_io = (sel_addr >= IO_BASE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner       <= OWNER_CPU;
            last_owner  <= OWNER_CPU;
            lat_we      <= 1'b0;
            d_addr_q    <= 16'h0000;
            d_wdata_q   <= 16'h0000;
            rdata_q     <= 16'h0000;
            d_oe_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            io_read_q   <= 1'b0;
            io_write_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    if (grant_valid) begin
                        owner       <= grant_owner;
                        last_owner  <= grant_owner;
                        lat_we      <= sel_we;
                        d_addr_q    <= sel_addr;
                        d_wdata_q   <= sel_wdata;
                        // Strobes are set on the way into CMD so they are valid for the whole CMD cycle.
                        d_oe_q      <= sel_we;
                        mem_read_q  <= ~sel_we & ~sel_io;
                        mem_write_q <=  sel_we & ~sel_io;
                        io_read_q   <= ~sel_we &  sel_io;
                        io_write_q  <=  sel_we &  sel_io;
                        state       <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (lat_we) begin
                        d_oe_q      <= 1'b0;
                        mem_write_q <= 1'b0;
                        io_write_q  <= 1'b0;
                        cpu_ack_q   <= (owner == OWNER_CPU);
                        dma_ack_q   <= (owner == OWNER_DMA);
                        state       <= ST_DONE;
                    end else begin
                        state       <= ST_RDAT;
                    end
                end
                ST_RDAT: begin
                    rdata_q    <= bus.d_bus_in;
                    mem_read_q <= 1'b0;
                    io_read_q  <= 1'b0;
                    cpu_ack_q  <= (owner == OWNER_CPU);
                    dma_ack_q  <= (owner == OWNER_DMA);
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    d_oe_q      <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    io_read_q   <= 1'b0;
                    io_write_q  <= 1'b0;
                    cpu_ack_q   <= 1'b0;
                    dma_ack_q   <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.d_addr    = d_addr_q;
    assign bus.d_wdata   = d_wdata_q;
    assign bus.d_oe      = d_oe_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.io_read   = io_read_q;
    assign bus.io_write  = io_write_q;

endmodule

// File: tb/tb_d_bus_arbiter.sv
// tb/tb_d_bus_arbiter.sv - directed self-checking bench for d_bus_arbiter
module tb_d_bus_arbiter;

    logic clk;
    logic rst_n;

    d_bus_arbiter_if bus ();

    d_bus_arbiter #(.IO_BASE(16'hFF00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    int n_mr, n_mw, n_ir, n_iw, n_oe, n_cpu_ack, n_dma_ack, ack_lat;
    logic oe_bad, multi;
    logic [15:0] rd_at_ack;
    logic [15:0] addr_at_cmd;
    int winner;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample_cycle();
        int ns;
        ns = int'(bus.mem_read) + int'(bus.mem_write) + int'(bus.io_read) + int'(bus.io_write);
        if (ns > 1) multi = 1'b1;
        if (bus.cpu_ack && bus.dma_ack) multi = 1'b1;
        if (bus.d_oe && !(bus.mem_write || bus.io_write)) oe_bad = 1'b1;
        n_mr += int'(bus.mem_read);
        n_mw += int'(bus.mem_write);
        n_ir += int'(bus.io_read);
        n_iw += int'(bus.io_write);
        n_oe += int'(bus.d_oe);
        n_cpu_ack += int'(bus.cpu_ack);
        n_dma_ack += int'(bus.dma_ack);
    endtask

    task automatic clear_stats();
        n_mr = 0; n_mw = 0; n_ir = 0; n_iw = 0; n_oe = 0;
        n_cpu_ack = 0; n_dma_ack = 0; ack_lat = -1;
        oe_bad = 1'b0; multi = 1'b0; rd_at_ack = 16'h0000; addr_at_cmd = 16'h0000;
    endtask

    // Called at a negedge; that cycle is the IDLE cycle with the request high (cycle 0).
    task automatic wait_ack();
        for (int cyc = 1; cyc <= 8 && ack_lat < 0; cyc++) begin
            @(negedge clk);
            sample_cycle();
            if (cyc == 1) addr_at_cmd = bus.d_addr;
            if (bus.cpu_ack || bus.dma_ack) begin
                ack_lat   = cyc;
                rd_at_ack = bus.rdata;
                winner    = bus.dma_ack ? 1 : 0;
            end
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        @(negedge clk);
        sample_cycle();
    endtask

    task automatic run_access(input logic is_dma, input logic we, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] bus_val);
        clear_stats();
        bus.d_bus_in = bus_val;
        if (is_dma) begin
            bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata; bus.dma_req = 1'b1;
        end else begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
        end
        wait_ack();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        winner   = 2;
        rst_n    = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 16'h0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 16'h0; bus.dma_wdata = 16'h0;
        bus.d_bus_in = 16'h0000;
        repeat (2) @(negedge clk);

        check_eq("reset_strobes", 32'({bus.mem_read, bus.mem_write, bus.io_read, bus.io_write, bus.d_oe}), 32'h0);
        check_eq("reset_acks", 32'({bus.cpu_ack, bus.dma_ack}), 32'h0);
        check_eq("reset_d_addr", 32'(bus.d_addr), 32'h0);
        check_eq("reset_d_wdata", 32'(bus.d_wdata), 32'h0);
        check_eq("reset_rdata", 32'(bus.rdata), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU memory write
        run_access(1'b0, 1'b1, 16'h0008, 16'h00AA, 16'h0000);
        check_eq("cpu_wr_mem_write_cycles", 32'(n_mw), 32'd1);
        check_eq("cpu_wr_d_oe_cycles", 32'(n_oe), 32'd1);
        check_eq("cpu_wr_oe_without_strobe", 32'(oe_bad), 32'd0);
        check_eq("cpu_wr_latency", 32'(ack_lat), 32'd2);
        check_eq("cpu_wr_d_addr", 32'(addr_at_cmd), 32'h0008);
        check_eq("cpu_wr_d_wdata", 32'(bus.d_wdata), 32'h00AA);
        check_eq("cpu_wr_acks", 32'({n_cpu_ack[7:0], n_dma_ack[7:0]}), 32'h0100);
        check_eq("cpu_wr_exclusive", 32'(multi), 32'd0);

        // CPU memory read
        run_access(1'b0, 1'b0, 16'h0008, 16'h0000, 16'h00AA);
        check_eq("cpu_rd_mem_read_cycles", 32'(n_mr), 32'd2);
        check_eq("cpu_rd_other_strobes", 32'(n_mw + n_ir + n_iw + n_oe), 32'd0);
        check_eq("cpu_rd_latency", 32'(ack_lat), 32'd3);
        check_eq("cpu_rd_rdata", 32'(rd_at_ack), 32'h00AA);
        check_eq("cpu_rd_rdata_held", 32'(bus.rdata), 32'h00AA);

        // DMA I/O write
        run_access(1'b1, 1'b1, 16'hFF02, 16'h5A5A, 16'h0000);
        check_eq("dma_wr_io_write_cycles", 32'(n_iw), 32'd1);
        check_eq("dma_wr_mem_write_cycles", 32'(n_mw), 32'd0);
        check_eq("dma_wr_dma_acks", 32'(n_dma_ack), 32'd1);
        check_eq("dma_wr_cpu_acks", 32'(n_cpu_ack), 32'd0);
        check_eq("dma_wr_latency", 32'(ack_lat), 32'd2);

        // IO_BASE boundary
        run_access(1'b0, 1'b0, 16'hFEFF, 16'h0000, 16'h1111);
        check_eq("rd_feff_mem_read", 32'(n_mr), 32'd2);
        check_eq("rd_feff_io_read", 32'(n_ir), 32'd0);
        run_access(1'b0, 1'b0, 16'hFF00, 16'h0000, 16'h2222);
        check_eq("rd_ff00_io_read", 32'(n_ir), 32'd2);
        check_eq("rd_ff00_mem_read", 32'(n_mr), 32'd0);
        check_eq("rd_ff00_rdata", 32'(rd_at_ack), 32'h2222);

        // Simultaneous requests after reset (last_owner = CPU)
        pulse_reset();
        for (int r = 0; r < 4; r++) begin
            int exp_w;
`ifdef ROUND_ROBIN_EN
            exp_w = (r % 2 == 0) ? 1 : 0;
`else
            exp_w = 0;
`endif
            clear_stats();
            winner = 2;
            bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0100; bus.cpu_wdata = 16'h1000;
            bus.dma_we = 1'b1; bus.dma_addr = 16'h0200; bus.dma_wdata = 16'h2000;
            bus.cpu_req = 1'b1;
            bus.dma_req = 1'b1;
            wait_ack();
            check_eq($sformatf("arb_round%0d_winner", r), 32'(winner), 32'(exp_w));
            check_eq($sformatf("arb_round%0d_d_addr", r), 32'(addr_at_cmd), (exp_w == 1) ? 32'h0200 : 32'h0100);
        end

        // Reset during RDAT aborts the read; held request is served afresh
        clear_stats();
        bus.d_bus_in = 16'h1234;
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_rdat_mem_read", 32'(bus.mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_strobes_dropped", 32'({bus.mem_read, bus.mem_write, bus.io_read, bus.io_write, bus.d_oe}), 32'h0);
        check_eq("abort_no_ack", 32'({bus.cpu_ack, bus.dma_ack}), 32'h0);
        #1;
        rst_n = 1'b1;
        wait_ack();
        check_eq("abort_rearb_latency", 32'(ack_lat), 32'd3);
        check_eq("abort_rearb_ack_count", 32'(n_cpu_ack), 32'd1);
        check_eq("abort_rearb_rdata", 32'(rd_at_ack), 32'h1234);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
